// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the receiver and the future transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int DATA_BITS    = 8;
    localparam int STREAM_WIDTH = 32;

    // Width of a counter that must reach divider-1 without wrapping.
    function automatic int div_width(input int divider);
        return (divider <= 2) ? 1 : $clog2(divider);
    endfunction

endpackage

// File: rtl/serial_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module serial_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the async input; both stages come out of reset high (line idle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_stream.sv
// 8N1 UART receiver presenting each received byte as a zero-extended stb/ack stream word.
module serial_rx_stream
    import serial_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [STREAM_WIDTH-1:0] out_data,
    output logic                    out_stb,
    input  logic                    out_ack,
    output logic                    framing_error,
    output logic                    overrun
);

    localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF    = DIVIDER / 2;
    localparam int CNT_W   = div_width(DIVIDER);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_next;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift_en;
    logic                 deliver;
    logic                 frame_err;

    serial_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // FSM state, baud counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // Next-state logic; every sample point resets the baud counter so it never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_cnt;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    bit_next = bit_cnt + 4'd1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line: wait for idle so only one framing error is reported.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Stream output: load on delivery unless a word is still held unacked, else flag overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data      <= '0;
            out_stb       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_err;
            overrun       <= 1'b0;
            if (deliver) begin
                if (!out_stb || out_ack) begin
                    out_data <= {(STREAM_WIDTH - DATA_BITS)'(0), shreg};
                    out_stb  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_stb && out_ack) begin
                out_stb <= 1'b0;
            end
        end
    end

endmodule
